// File: rtl/dmem_responder.sv
// ============================================================================
// Module   : dmem_responder
// Purpose  : Single-outstanding data-memory target with fixed wait states.
//            Optional alignment/range error checking enabled by DMEM_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder #(
    parameter int WORDS   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int C_AW = $clog2(WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [C_AW-1:0]   idx_q, idx_d;
    logic              err_q, err_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;

    logic [31:0]       mem [WORDS];

    logic              w_accept;
    logic [C_AW-1:0]   w_req_idx;
    logic              w_req_err;
    logic              w_enter_resp;
    logic [C_AW-1:0]   w_rd_idx;
    logic              w_rd_we;
    logic              w_rd_err;

    assign w_accept  = req_valid & req_ready_q;
    assign w_req_idx = req_addr[C_AW+1:2];

`ifdef DMEM_ERR_EN
    assign w_req_err = (req_addr[1:0] != 2'b00) || ((req_addr >> (C_AW + 2)) != 32'd0);
`else
    // Without checking, the low byte offset and upper address bits are don't-care.
    logic w_unused_addr;
    assign w_unused_addr = ^{req_addr[1:0], req_addr >> (C_AW + 2)};
    assign w_req_err     = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        idx_d        = idx_q;
        err_d        = err_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        w_enter_resp = 1'b0;
        w_rd_idx     = idx_q;
        w_rd_we      = we_q;
        w_rd_err     = err_q;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    we_d        = req_we;
                    idx_d       = w_req_idx;
                    err_d       = w_req_err;
                    req_ready_d = 1'b0;
                    if (LATENCY == 0) begin
                        // Zero wait states: the read happens on the acceptance edge itself.
                        state_d      = S_RESP;
                        w_enter_resp = 1'b1;
                        w_rd_idx     = w_req_idx;
                        w_rd_we      = req_we;
                        w_rd_err     = w_req_err;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(LATENCY);
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d      = S_RESP;
                    w_enter_resp = 1'b1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d      = S_IDLE;
                    req_ready_d  = 1'b1;
                    resp_valid_d = 1'b0;
                    resp_rdata_d = 32'd0;
                    resp_err_d   = 1'b0;
                end
            end
            default: begin
                state_d      = S_IDLE;
                cnt_d        = 4'd0;
                req_ready_d  = 1'b1;
                resp_valid_d = 1'b0;
                resp_rdata_d = 32'd0;
                resp_err_d   = 1'b0;
            end
        endcase

        if (w_enter_resp) begin
            resp_valid_d = 1'b1;
            resp_err_d   = w_rd_err;
            resp_rdata_d = (w_rd_we || w_rd_err) ? 32'd0 : mem[w_rd_idx];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            idx_q        <= '0;
            err_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            idx_q        <= idx_d;
            err_q        <= err_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Array contents survive reset; stores commit on the acceptance edge.
    always_ff @(posedge clk) begin
        if (w_accept && req_we && !w_req_err) begin
            for (int i = 0; i < 4; i++) begin
                if (req_be[i]) begin
                    mem[w_req_idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Directed plus random checks of dmem_responder at LATENCY 2 and 0.
//            Expectations follow DMEM_ERR_EN when the macro is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;

    localparam int WORDS = 1024;
`ifdef DMEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sel = 1'b0;
    logic        drv_valid = 1'b0;
    logic        drv_we = 1'b0;
    logic        drv_rready = 1'b1;
    logic [31:0] drv_addr = 32'd0;
    logic [31:0] drv_wdata = 32'd0;
    logic [3:0]  drv_be = 4'd0;

    logic        rqv_a, rqv_b, rsr_a, rsr_b;
    logic        rdy_a, rdy_b, val_a, val_b, err_a, err_b;
    logic [31:0] rd_a, rd_b;
    logic        o_ready, o_valid, o_err;
    logic [31:0] o_rdata;

    int          total = 0;
    int          bad = 0;
    int          pcyc = 0;
    logic [31:0] ref_mem [2][WORDS];

    assign rqv_a = drv_valid & ~sel;
    assign rqv_b = drv_valid & sel;
    assign rsr_a = sel | drv_rready;
    assign rsr_b = ~sel | drv_rready;

    assign o_ready = sel ? rdy_b : rdy_a;
    assign o_valid = sel ? val_b : val_a;
    assign o_rdata = sel ? rd_b : rd_a;
    assign o_err   = sel ? err_b : err_a;

    dmem_responder #(.WORDS(WORDS), .LATENCY(2)) u_dut_a (
        .clk(clk), .reset(reset),
        .req_valid(rqv_a), .req_ready(rdy_a), .req_we(drv_we),
        .req_addr(drv_addr), .req_wdata(drv_wdata), .req_be(drv_be),
        .resp_valid(val_a), .resp_ready(rsr_a), .resp_rdata(rd_a), .resp_err(err_a)
    );

    dmem_responder #(.WORDS(WORDS), .LATENCY(0)) u_dut_b (
        .clk(clk), .reset(reset),
        .req_valid(rqv_b), .req_ready(rdy_b), .req_we(drv_we),
        .req_addr(drv_addr), .req_wdata(drv_wdata), .req_be(drv_be),
        .resp_valid(val_b), .resp_ready(rsr_b), .resp_rdata(rd_b), .resp_err(err_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) pcyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Handshake exclusivity on both instances, every cycle.
    always @(negedge clk) begin
        chk("overlap_a", {31'd0, rdy_a & val_a}, 32'd0);
        chk("overlap_b", {31'd0, rdy_b & val_b}, 32'd0);
    end

    // Reference: apply the access to the model and return the expected response.
    task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, output logic e_err, output logic [31:0] e_rd);
        int idx;
        idx   = int'((addr >> 2) % WORDS);
        e_err = ERR_EN && (((addr % 4) != 0) || (addr >= 32'(4 * WORDS)));
        if (we && !e_err)
            for (int i = 0; i < 4; i++)
                if (be[i]) ref_mem[sel][idx][8*i +: 8] = wdata[8*i +: 8];
        e_rd = (we || e_err) ? 32'd0 : ref_mem[sel][idx];
    endtask

    // Called at a negedge with the selected responder idle; returns at a negedge.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int stall, output int acc);
        int          k;
        int          lat;
        logic        e_err;
        logic [31:0] e_rd;
        lat       = sel ? 0 : 2;
        drv_we    = we;
        drv_addr  = addr;
        drv_wdata = wdata;
        drv_be    = be;
        drv_valid = 1'b1;
        k = 0;
        while (o_ready !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        chk("req_ready", {31'd0, o_ready}, 32'd1);
        @(posedge clk);
        model(we, addr, wdata, be, e_err, e_rd);
        @(negedge clk);
        acc        = pcyc;
        drv_valid  = 1'b0;
        drv_rready = (stall == 0);
        k = 1;
        while (o_valid !== 1'b1 && k < 20) begin
            chk("ready_busy", {31'd0, o_ready}, 32'd0);
            @(negedge clk);
            k++;
        end
        chk("latency", 32'(k), 32'(lat + 1));
        chk("rdata", o_rdata, e_rd);
        chk("err", {31'd0, o_err}, {31'd0, e_err});
        chk("ready_in_resp", {31'd0, o_ready}, 32'd0);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, o_valid}, 32'd1);
            chk("hold_rdata", o_rdata, e_rd);
            chk("hold_err", {31'd0, o_err}, {31'd0, e_err});
            chk("hold_ready", {31'd0, o_ready}, 32'd0);
        end
        drv_rready = 1'b1;
        @(negedge clk);
        chk("valid_drop", {31'd0, o_valid}, 32'd0);
        chk("ready_back", {31'd0, o_ready}, 32'd1);
    endtask

    initial begin
        int          acc, prev;
        logic        e_err;
        logic [31:0] e_rd;
        logic [31:0] a;

        repeat (3) @(negedge clk);
        chk("rst_ready_a", {31'd0, rdy_a}, 32'd1);
        chk("rst_valid_a", {31'd0, val_a}, 32'd0);
        chk("rst_rdata_a", rd_a, 32'd0);
        chk("rst_err_a", {31'd0, err_a}, 32'd0);
        chk("rst_ready_b", {31'd0, rdy_b}, 32'd1);
        chk("rst_valid_b", {31'd0, val_b}, 32'd0);
        chk("rst_rdata_b", rd_b, 32'd0);
        chk("rst_err_b", {31'd0, err_b}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Full store, partial store, empty-enable store, stalled response.
        sel = 1'b0;
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, acc);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, acc);
        do_req(1'b1, 32'h10, 32'h000000AA, 4'h1, 0, acc);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, acc);
        do_req(1'b1, 32'h10, 32'h11223344, 4'h0, 0, acc);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 5, acc);
        chk("partial_word", ref_mem[0][4], 32'hDEADBEAA);

        // Misaligned and out-of-range accesses.
        do_req(1'b1, 32'h0, 32'h0BADF00D, 4'hF, 0, acc);
        do_req(1'b0, 32'h12, 32'h0, 4'h0, 0, acc);
        do_req(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 1, acc);
        do_req(1'b0, 32'h0, 32'h0, 4'h0, 0, acc);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, acc);

        // Zero-latency instance, back-to-back with resp_ready held high.
        sel = 1'b1;
        for (int i = 0; i < 4; i++)
            do_req(1'b1, 32'h40 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 4'hF, 0, acc);
        do_req(1'b0, 32'h40, 32'h0, 4'h0, 0, prev);
        for (int i = 1; i < 4; i++) begin
            do_req(1'b0, 32'h40 + 32'(4 * i), 32'h0, 4'h0, 0, acc);
            chk("throughput", 32'(acc - prev), 32'd2);
            prev = acc;
        end

        // Reset during WAIT drops a pending load.
        sel = 1'b0;
        drv_we = 1'b0; drv_addr = 32'h10; drv_be = 4'h0; drv_valid = 1'b1;
        chk("pre_ready", {31'd0, o_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        drv_valid = 1'b0;
        chk("in_wait_ready", {31'd0, o_ready}, 32'd0);
        reset = 1'b0;
        #1;
        chk("mid_rst_ready", {31'd0, o_ready}, 32'd1);
        chk("mid_rst_valid", {31'd0, o_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_valid", {31'd0, o_valid}, 32'd0);
            chk("post_rst_ready", {31'd0, o_ready}, 32'd1);
        end

        // A store interrupted by reset after acceptance stays committed.
        drv_we = 1'b1; drv_addr = 32'h20; drv_wdata = 32'h12345678; drv_be = 4'hF;
        drv_valid = 1'b1;
        @(posedge clk);
        model(1'b1, 32'h20, 32'h12345678, 4'hF, e_err, e_rd);
        @(negedge clk);
        drv_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        do_req(1'b0, 32'h20, 32'h0, 4'h0, 0, acc);
        do_req(1'b1, 32'h4, 32'h5, 4'hF, 0, acc);
        do_req(1'b0, 32'h4, 32'h0, 4'h0, 0, acc);

        // Random traffic over a small initialised window on both instances.
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            for (int w = 0; w < 16; w++)
                do_req(1'b1, 32'h100 + 32'(4 * w), $urandom, 4'hF, 0, acc);
            for (int n = 0; n < 40; n++) begin
                a = 32'h100 + 32'(4 * $urandom_range(0, 15));
                if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 3));
                if ($urandom_range(0, 7) == 0) a = a + 32'h1000 * 32'($urandom_range(1, 3));
                do_req(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 2), acc);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
